lock_seq_ctrl: RTL and testbench
================================

Name: lock_seq_ctrl

Overview:
- Password-entry controller for the combination-lock datapath.
- Collects a fixed-length sequence of keypad digits and compares it against a stored code.
- Drives the 1-bit "sorted/match" status register through its LD and sorted_CLR controls, and counts failed attempts.
- Enforces a timed lockout after repeated failures; sits between keypad debounce/decoding and the match register / display logic.

Parameters:
- DW, 3, bits per entered digit
- NDIG, 4, digits per password
- MAX_FAIL, 3, consecutive failures before lockout (>=1)
- LOCK_CYC, 16, lockout duration in CLK cycles (>=1)
- OPEN_CYC, 8, cycles UNLOCKED stays high after a match (>=1)
- DEFAULT_PW, 0, NDIG*DW-bit code loaded at reset
- TIMEOUT_CYC, 32, idle-entry timeout in cycles (optional feature only)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  synchronous active-low reset
- ENTER  in  1  one-cycle strobe: DIGIT valid
- DIGIT  in  DW  entered digit
- SET_PW  in  1  strobe: load NEW_PW (honoured only in OPEN)
- NEW_PW  in  NDIG*DW  replacement code; digit 0 in the LSBs
- LD  out  1  one-cycle pulse to the match register on success
- sorted_CLR  out  1  one-cycle pulse clearing the match register
- UNLOCKED  out  1  high while in OPEN
- LOCKOUT  out  1  high while in LOCKED
- BUSY  out  1  high while in COLLECT
- FAILS  out  $clog2(MAX_FAIL+1)  consecutive-failure count

Behaviour:
- One clock, CLK. RST_N is synchronous, active-low, sampled on the rising edge of CLK.
- Reset:
  - state = IDLE; stored code = DEFAULT_PW.
  - Digit index = 0, mismatch flag = 0, FAILS = 0, timers = 0.
  - All outputs 0.
  - Reset overrides any operation in progress.
- IDLE:
  - ENTER compares DIGIT with code digit 0, sets the mismatch flag if they differ, sets index = 1, and moves to COLLECT.
  - If NDIG == 1, ENTER goes directly to CHECK.
- COLLECT:
  - BUSY = 1.
  - Each ENTER compares DIGIT with code digit [index] and ORs any difference into the mismatch flag.
  - No early reject: all NDIG digits are always consumed.
  - When the NDIG-th digit is accepted, go to CHECK on the next cycle.
  - Cycles without ENTER hold state.
- CHECK (exactly 1 cycle, ENTER ignored):
  - Match: LD = 1 this cycle, FAILS -> 0, go to OPEN.
  - Mismatch: sorted_CLR = 1 this cycle, FAILS += 1.
    - If the new FAILS == MAX_FAIL, go to LOCKED.
    - Otherwise go to IDLE.
  - Index and mismatch flag are cleared on exit.
- Latency: LD or sorted_CLR is asserted 1 cycle after the CLK edge that samples the last ENTER.
- OPEN:
  - UNLOCKED = 1 for exactly OPEN_CYC cycles; ENTER ignored.
  - SET_PW replaces the stored code with NEW_PW on that edge.
  - SET_PW and the final OPEN cycle in the same cycle: the load still takes effect.
  - On exit: sorted_CLR = 1 for 1 cycle, then go to IDLE.
  - SET_PW in any other state is ignored.
- LOCKED:
  - LOCKOUT = 1 for exactly LOCK_CYC cycles; ENTER and SET_PW ignored.
  - On expiry: FAILS -> 0, go to IDLE.
- FAILS saturates at MAX_FAIL; it cannot wrap.
- LD and sorted_CLR are never high in the same cycle.
- All outputs are registered or decoded directly from state; no combinational path from ENTER to outputs.

Optional Feature:
- Macro: LOCK_SEQ_ENTRY_TIMEOUT_EN.
- Defined:
  - In COLLECT, an idle counter counts cycles without ENTER and resets on each ENTER.
  - When the counter reaches TIMEOUT_CYC, the partial entry is aborted: sorted_CLR = 1 for 1 cycle, index and flag cleared, go to IDLE.
  - FAILS is not incremented.
  - ENTER on the timeout cycle wins: the digit is accepted and the counter resets.
- Undefined:
  - No idle counter exists; COLLECT waits indefinitely.
  - TIMEOUT_CYC is unused.

Decomposition:
- Package lock_pkg holds:
  - typedef enum logic [2:0] lock_state_t {IDLE, COLLECT, CHECK, OPEN, LOCKED}.
  - Shared default parameter constants (DW, NDIG).
- Sub-module lock_timer: loadable down-counter.
  - Ports: CLK, RST_N, load, load_val, done.
  - Instantiated once and reused for OPEN_CYC, LOCK_CYC and, when the feature is enabled, TIMEOUT_CYC.
  - Only one of these timers runs at a time.

Test Plan:
- Correct code after reset (DEFAULT_PW=0, digits 0,0,0,0) -> LD pulses 1 cycle after the 4th ENTER; UNLOCKED high 8 cycles; then one sorted_CLR pulse; back in IDLE.
- Wrong code (0,0,0,5) -> no LD; sorted_CLR pulses once; FAILS=1. A following correct entry gives LD and FAILS=0.
- Three wrong entries in a row -> FAILS=3; LOCKOUT high 16 cycles. ENTERs during lockout have no effect. Afterwards FAILS=0 and a correct entry unlocks.
- In OPEN, SET_PW with NEW_PW={3'd7,3'd1,3'd2,3'd3} (digits 3,2,1,7) -> old code now fails and digits 3,2,1,7 unlock. SET_PW in IDLE has no effect.
- RST_N low in the middle of COLLECT (after 2 digits) -> next cycle all outputs 0; the next full correct entry unlocks with no leftover digits.
- With LOCK_SEQ_ENTRY_TIMEOUT_EN defined: 2 digits then 32 idle cycles -> sorted_CLR pulses; state is IDLE; FAILS unchanged. Without the macro, same stimulus -> BUSY stays high.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and default constants for the combination-lock sequence controller.
package lock_pkg;

    localparam int unsigned DEF_DW   = 3;
    localparam int unsigned DEF_NDIG = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        OPEN    = 3'd3,
        LOCKED  = 3'd4
    } lock_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done is high during the last cycle of a loaded interval.
module lock_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          done
);

    logic [TW-1:0] count_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == TW'(1));

endmodule

// File: rtl/lock_seq_ctrl.sv
// Password-entry controller: digit collection, match/fail decision, open window and lockout.
// Optional idle-entry abort in COLLECT is enabled by defining LOCK_SEQ_ENTRY_TIMEOUT_EN.
module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned            DW          = DEF_DW,
    parameter int unsigned            NDIG        = DEF_NDIG,
    parameter int unsigned            MAX_FAIL    = 3,
    parameter int unsigned            LOCK_CYC    = 16,
    parameter int unsigned            OPEN_CYC    = 8,
    parameter logic [NDIG*DW-1:0]     DEFAULT_PW  = '0,
    parameter int unsigned            TIMEOUT_CYC = 32
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          ENTER,
    input  logic [DW-1:0]                 DIGIT,
    input  logic                          SET_PW,
    input  logic [NDIG*DW-1:0]            NEW_PW,
    output logic                          LD,
    output logic                          sorted_CLR,
    output logic                          UNLOCKED,
    output logic                          LOCKOUT,
    output logic                          BUSY,
    output logic [$clog2(MAX_FAIL+1)-1:0] FAILS
);

    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMAX = max3(OPEN_CYC, LOCK_CYC, TIMEOUT_CYC);
    localparam int unsigned TW   = $clog2(TMAX + 1);

    lock_state_t          state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 mis_q, mis_d;
    logic [FW-1:0]        fails_q, fails_d, fails_inc;
    logic [NDIG*DW-1:0]   code_q, code_d;
    logic                 clr_q, clr_d;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_done;
    logic [DW-1:0]        cur_dig;

    lock_timer #(
        .TW (TW)
    ) u_timer (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign cur_dig   = code_q[int'(idx_q)*DW +: DW];
    assign fails_inc = (fails_q == FW'(MAX_FAIL)) ? fails_q : fails_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        fails_d  = fails_q;
        code_d   = code_q;
        clr_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            IDLE: begin
                if (ENTER) begin
                    mis_d = (DIGIT != code_q[DW-1:0]);
                    if (NDIG == 1) begin
                        state_d = CHECK;
                        idx_d   = '0;
                    end else begin
                        state_d  = COLLECT;
                        idx_d    = IW'(1);
                        tmr_load = 1'b1;
                        tmr_val  = TW'(TIMEOUT_CYC);
                    end
                end
            end
            COLLECT: begin
                if (ENTER) begin
                    mis_d    = mis_q | (DIGIT != cur_dig);
                    tmr_load = 1'b1;
                    tmr_val  = TW'(TIMEOUT_CYC);
                    if (idx_q == IW'(NDIG - 1)) begin
                        state_d = CHECK;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
                else if (tmr_done) begin
                    // Abandoned partial entry: discard it without counting a failure.
                    state_d = IDLE;
                    idx_d   = '0;
                    mis_d   = 1'b0;
                    clr_d   = 1'b1;
                end
`endif
            end
            CHECK: begin
                idx_d    = '0;
                mis_d    = 1'b0;
                tmr_load = 1'b1;
                if (!mis_q) begin
                    fails_d = '0;
                    state_d = OPEN;
                    tmr_val = TW'(OPEN_CYC);
                end else begin
                    fails_d = fails_inc;
                    if (fails_inc == FW'(MAX_FAIL)) begin
                        state_d = LOCKED;
                        tmr_val = TW'(LOCK_CYC);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OPEN: begin
                if (SET_PW) begin
                    code_d = NEW_PW;
                end
                if (tmr_done) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            LOCKED: begin
                if (tmr_done) begin
                    fails_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            fails_q <= '0;
            code_q  <= DEFAULT_PW;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            fails_q <= fails_d;
            code_q  <= code_d;
            clr_q   <= clr_d;
        end
    end

    // clr_q only rises on entry to IDLE, so it can never coincide with the CHECK pulses.
    assign LD         = (state_q == CHECK) && !mis_q;
    assign sorted_CLR = ((state_q == CHECK) && mis_q) || clr_q;
    assign UNLOCKED   = (state_q == OPEN);
    assign LOCKOUT    = (state_q == LOCKED);
    assign BUSY       = (state_q == COLLECT);
    assign FAILS      = fails_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed self-checking bench for lock_seq_ctrl (default parameters).
module tb_lock_seq_ctrl;

    logic       CLK;
    logic       RST_N;
    logic       ENTER;
    logic [2:0] DIGIT;
    logic       SET_PW;
    logic [11:0] NEW_PW;
    logic       LD;
    logic       sorted_CLR;
    logic       UNLOCKED;
    logic       LOCKOUT;
    logic       BUSY;
    logic [1:0] FAILS;

    int n_checks = 0;
    int n_pass   = 0;

    lock_seq_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .ENTER      (ENTER),
        .DIGIT      (DIGIT),
        .SET_PW     (SET_PW),
        .NEW_PW     (NEW_PW),
        .LD         (LD),
        .sorted_CLR (sorted_CLR),
        .UNLOCKED   (UNLOCKED),
        .LOCKOUT    (LOCKOUT),
        .BUSY       (BUSY),
        .FAILS      (FAILS)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // {LD, sorted_CLR, UNLOCKED, LOCKOUT, BUSY}
    function automatic logic [31:0] outs();
        return {27'd0, LD, sorted_CLR, UNLOCKED, LOCKOUT, BUSY};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic enter_digit(input logic [2:0] d);
        ENTER = 1'b1;
        DIGIT = d;
        tick();
        ENTER = 1'b0;
    endtask

    task automatic enter_code(input logic [2:0] d0, input logic [2:0] d1,
                              input logic [2:0] d2, input logic [2:0] d3);
        enter_digit(d0);
        enter_digit(d1);
        enter_digit(d2);
        enter_digit(d3);
    endtask

    // Counts UNLOCKED cycles from the current sample, then checks the closing clear pulse.
    task automatic count_open(input string tag, input int exp);
        int n = 0;
        while (UNLOCKED && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_open_cycles"}, n, exp);
        check({tag, "_exit_clr"}, outs(), 32'b01000);
        tick();
        check({tag, "_idle"}, outs(), 32'b00000);
    endtask

    initial begin
        RST_N  = 1'b0;
        ENTER  = 1'b0;
        DIGIT  = '0;
        SET_PW = 1'b0;
        NEW_PW = '0;
        tick();
        tick();
        check("reset_outs", outs(), 32'b00000);
        check("reset_fails", FAILS, 0);
        RST_N = 1'b1;

        // Correct default code
        enter_digit(3'd0);
        check("collect_busy", outs(), 32'b00001);
        enter_digit(3'd0);
        enter_digit(3'd0);
        enter_digit(3'd0);
        check("ok_ld", outs(), 32'b10000);
        tick();
        count_open("ok", 8);

        // Wrong then correct
        enter_code(3'd0, 3'd0, 3'd0, 3'd5);
        check("bad_clr", outs(), 32'b01000);
        tick();
        check("bad_idle", outs(), 32'b00000);
        check("bad_fails1", FAILS, 1);
        enter_code(3'd0, 3'd0, 3'd0, 3'd0);
        check("retry_ld", outs(), 32'b10000);
        tick();
        check("retry_fails0", FAILS, 0);
        count_open("retry", 8);

        // Three failures -> lockout
        for (int i = 0; i < 3; i++) begin
            enter_code(3'd1, 3'd0, 3'd0, 3'd0);
            check("lk_clr", outs(), 32'b01000);
            tick();
        end
        check("lk_fails3", FAILS, 3);
        check("lk_lockout", outs(), 32'b00010);
        begin
            int n = 0;
            while (LOCKOUT && n < 100) begin
                n++;
                ENTER = 1'b1;
                DIGIT = 3'd0;
                tick();
            end
            ENTER = 1'b0;
            check("lk_cycles", n, 16);
        end
        check("lk_after_outs", outs(), 32'b00000);
        check("lk_after_fails", FAILS, 0);
        enter_code(3'd0, 3'd0, 3'd0, 3'd0);
        check("lk_after_ld", outs(), 32'b10000);
        tick();
        check("lk_after_open", outs(), 32'b00100);

        // Password change while OPEN (we are in the first OPEN cycle)
        SET_PW = 1'b1;
        NEW_PW = {3'd7, 3'd1, 3'd2, 3'd3};
        tick();
        SET_PW = 1'b0;
        NEW_PW = '0;
        count_open("setpw", 7);
        enter_code(3'd0, 3'd0, 3'd0, 3'd0);
        check("oldpw_rejected", outs(), 32'b01000);
        tick();
        enter_code(3'd3, 3'd2, 3'd1, 3'd7);
        check("newpw_ld", outs(), 32'b10000);
        tick();
        count_open("newpw", 8);
        SET_PW = 1'b1;
        NEW_PW = '0;
        tick();
        SET_PW = 1'b0;
        enter_code(3'd3, 3'd2, 3'd1, 3'd7);
        check("idle_setpw_ignored", outs(), 32'b10000);
        tick();
        count_open("idle_setpw", 8);

        // Reset mid-entry restores default code and clears partial digits
        enter_digit(3'd3);
        enter_digit(3'd2);
        check("mid_busy", outs(), 32'b00001);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("mid_reset_outs", outs(), 32'b00000);
        enter_digit(3'd0);
        enter_digit(3'd0);
        enter_digit(3'd0);
        check("mid_no_leftover", outs(), 32'b00001);
        enter_digit(3'd0);
        check("mid_ld", outs(), 32'b10000);
        tick();
        count_open("mid", 8);

        // Idle during entry (with one prior failure recorded)
        enter_code(3'd0, 3'd0, 3'd0, 3'd6);
        tick();
        check("to_fails1", FAILS, 1);
        enter_digit(3'd0);
        enter_digit(3'd0);
        for (int i = 0; i < 31; i++) tick();
        check("to_busy31", outs(), 32'b00001);
        tick();
`ifdef LOCK_SEQ_ENTRY_TIMEOUT_EN
        check("to_abort_clr", outs(), 32'b01000);
        check("to_fails_kept", FAILS, 1);
        tick();
        check("to_idle", outs(), 32'b00000);
`else
        check("to_still_busy", outs(), 32'b00001);
        check("to_fails_kept", FAILS, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
